dispatch_queue: RTL
===================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of buffered entries; power of two, at least 2*WIDTH.
REQ-002 SHALL have parameter WIDTH, default 2: slots per cycle on both input and output sides.
REQ-003 SHALL have parameter ENTRY_W, default 96: opaque issue-entry payload width.
REQ-004 SHALL have parameter NTYPE, default 4: number of issue-queue types; TYPE_W = $clog2(NTYPE).
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-008 SHALL have port in_valid, input, WIDTH bits: per-slot request from rename.
REQ-009 SHALL have port in_entry, input, WIDTH*ENTRY_W bits: per-slot payload.
REQ-010 SHALL have port in_type, input, WIDTH*TYPE_W bits: per-slot target issue-queue type.
REQ-011 SHALL have port in_ready, output, 1 bit: a whole input group is accepted this cycle.
REQ-012 SHALL have port out_valid, output, WIDTH bits: per-slot write request to the issue queues.
REQ-013 SHALL have port out_entry, output, WIDTH*ENTRY_W bits: per-slot payload.
REQ-014 SHALL have port out_type, output, WIDTH*TYPE_W bits: per-slot target type.
REQ-015 SHALL have port iq_full, input, NTYPE bits: registered full flag per issue queue, bit index = type.

Function
REQ-016 SHALL store entries in a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register of $clog2(DEPTH)+1 bits.
REQ-017 SHALL drive in_ready = 1 iff DEPTH - count >= WIDTH, using count at the start of the cycle; in_ready SHALL be independent of in_valid and iq_full.
REQ-018 SHALL treat in_valid as compacted: set bits contiguous from slot 0; a non-compacted pattern is illegal input and its behaviour is unspecified.
REQ-019 SHALL, when in_ready is 1, enqueue popcount(in_valid) entries in slot order at tail, and advance tail by that amount; when in_ready is 0, inputs SHALL be ignored.
REQ-020 SHALL present output slot k (k = 0..WIDTH-1) from FIFO position head+k (mod DEPTH) only if k < count.
REQ-021 SHALL assert out_valid[k] iff slot k is presentable, iq_full[out_type[k]] is 0, and out_valid[k-1] is 1 for k > 0 (strict program order; first blocked slot blocks all younger slots).
REQ-022 SHALL treat every asserted out_valid slot as consumed in the same cycle (no accept return); head SHALL advance by popcount(out_valid).
REQ-023 SHALL update count = count + enqueued - dequeued each cycle; count SHALL never exceed DEPTH nor go below 0.
REQ-024 SHALL provide no input-to-output bypass: an entry enqueued in cycle t appears on the output at t+1 earliest (latency 1 cycle).
REQ-025 SHALL allow simultaneous enqueue and dequeue in the same cycle, including when count = DEPTH - WIDTH and when pointers wrap.
REQ-026 SHALL drive out_entry/out_type for slots with out_valid = 0 as don't-care, and out_valid SHALL be 0 for all slots when count = 0.
REQ-027 SHALL, on flush = 1, set head, tail, count to 0 at the next edge, discard same-cycle input, and still drive this cycle's outputs per REQ-021.

Reset
REQ-028 SHALL, while resetn = 0 at a rising edge, set head = tail = count = 0; flush and resetn SHALL have equal effect on state.
REQ-029 SHALL, after reset, present out_valid = 0 and in_ready = 1 (given DEPTH >= WIDTH); reset mid-operation drops all buffered entries.

Verification
REQ-030 SHALL pass: reset, then in_valid=2'b11, types {0,1}, iq_full=0 -> next cycle out_valid=2'b11 with same payloads in order, count returns to 0.
REQ-031 SHALL pass: DEPTH=8, iq_full=4'b1111, push 2 per cycle for 4 cycles -> count=8, in_ready=0 in cycle 5, 5th group ignored.
REQ-032 SHALL pass: head entry type 2, iq_full[2]=1, second entry type 0 -> out_valid=2'b00; deassert iq_full[2] -> out_valid=2'b11 next cycle.
REQ-033 SHALL pass: head type 0 ready, slot 1 type 3 with iq_full[3]=1 -> out_valid=2'b01, head advances by 1.
REQ-034 SHALL pass: 20 cycles of random push/pop with pointer wrap -> output sequence equals input sequence exactly, no loss or duplication.
REQ-035 SHALL pass: count=5, flush=1 with in_valid=2'b11 -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: circular FIFO between rename and the issue queues, WIDTH slots in and out per cycle.
module dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int ENTRY_W = 96,
  parameter int NTYPE = 4,
  localparam int TYPE_W = $clog2(NTYPE)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_valid,
  input  logic [WIDTH*ENTRY_W-1:0]   in_entry,
  input  logic [WIDTH*TYPE_W-1:0]    in_type,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_valid,
  output logic [WIDTH*ENTRY_W-1:0]   out_entry,
  output logic [WIDTH*TYPE_W-1:0]    out_type,
  input  logic [NTYPE-1:0]           iq_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ENTRY_W-1:0] mem_entry [DEPTH];
  logic [TYPE_W-1:0]  mem_type [DEPTH];
  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count, n_in, n_out, n_req;
  logic               go;
  assign in_ready = count <= CW'(DEPTH - WIDTH);
  always_comb begin
    n_req = '0;
    for (int k = 0; k < WIDTH; k++) n_req = n_req + CW'(in_valid[k]);
    n_in = in_ready ? n_req : '0;
  end
  // Slots drain strictly in order: the first blocked slot holds back every younger one.
  always_comb begin
    go = 1'b1;
    n_out = '0;
    out_valid = '0;
    out_entry = '0;
    out_type = '0;
    for (int k = 0; k < WIDTH; k++) begin
      out_entry[k*ENTRY_W +: ENTRY_W] = mem_entry[head + PW'(k)];
      out_type[k*TYPE_W +: TYPE_W] = mem_type[head + PW'(k)];
      go = go && (CW'(k) < count) && !iq_full[mem_type[head + PW'(k)]];
      out_valid[k] = go;
      n_out = n_out + CW'(go);
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(n_out);
      tail <= tail + PW'(n_in);
      count <= count + n_in - n_out;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++)
      if (in_ready && in_valid[k]) begin
        mem_entry[tail + PW'(k)] <= in_entry[k*ENTRY_W +: ENTRY_W];
        mem_type[tail + PW'(k)] <= in_type[k*TYPE_W +: TYPE_W];
      end
  end
endmodule
